// File: rtl/tone_pkg.sv
// tone_pkg: direction codes, FSM states and default timing for the tone link
package tone_pkg;

    typedef enum logic [2:0] {
        STRAIGHT = 3'b000,
        LEFT     = 3'b001,
        RIGHT    = 3'b010,
        BACK     = 3'b011,
        STOP     = 3'b100
    } dir_e;

    typedef enum logic [1:0] {
        IDLE,
        TONE,
        GAP
    } state_e;

    localparam int DEF_HP_STRAIGHT = 25_000;
    localparam int DEF_HP_LEFT     = 16_667;
    localparam int DEF_HP_RIGHT    = 12_500;
    localparam int DEF_HP_BACK     = 10_000;
    localparam int DEF_TONE_CYCLES = 25_000_000;
    localparam int DEF_GAP_CYCLES  = 25_000_000;

    function automatic int cw(input int v);
        return $clog2(v + 1);
    endfunction

    function automatic int max2(input int a, input int b);
        return a > b ? a : b;
    endfunction

endpackage

// File: rtl/tone_generator_if.sv
// tone_generator_if: command handshake and tone status bundle
interface tone_generator_if;
    logic       cmd_valid;
    logic [2:0] cmd_dir;
    logic       cmd_ready;
    logic       tone_out;
    logic       active;
    logic       done;

    modport master (
        output cmd_valid, cmd_dir,
        input  cmd_ready, tone_out, active, done
    );

    modport slave (
        input  cmd_valid, cmd_dir,
        output cmd_ready, tone_out, active, done
    );
endinterface

// File: rtl/tone_divider.sv
// tone_divider: half-period counter with toggle flop, starts high when enabled
module tone_divider #(
    parameter int W = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] half_period,
    output logic         sq
);
    logic [W-1:0] cnt;
    logic         run;

    // first enabled edge drives sq high, then it toggles every half_period cycles
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
            sq  <= 1'b0;
            run <= 1'b0;
        end else if (!run) begin
            cnt <= '0;
            sq  <= 1'b1;
            run <= 1'b1;
        end else if (cnt == half_period - W'(1)) begin
            cnt <= '0;
            sq  <= ~sq;
        end else begin
            cnt <= cnt + W'(1);
        end
    end
endmodule

// File: rtl/tone_generator.sv
// tone_generator: turns a direction command into a timed square-wave burst plus silent gap
module tone_generator
    import tone_pkg::*;
#(
    parameter int HP_STRAIGHT = DEF_HP_STRAIGHT,
    parameter int HP_LEFT     = DEF_HP_LEFT,
    parameter int HP_RIGHT    = DEF_HP_RIGHT,
    parameter int HP_BACK     = DEF_HP_BACK,
    parameter int TONE_CYCLES = DEF_TONE_CYCLES,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
    input logic            clk,
    input logic            rst,
    tone_generator_if.slave bus
);
    localparam int HP_MAX = max2(max2(HP_STRAIGHT, HP_LEFT), max2(HP_RIGHT, HP_BACK));
    localparam int HW = cw(HP_MAX);
    localparam int TW = cw(TONE_CYCLES);
    localparam int GW = cw(GAP_CYCLES);

    state_e        state, state_n;
    logic [HW-1:0] hp, hp_sel;
    logic [TW-1:0] bcnt;
    logic [GW-1:0] gcnt;
    logic          start, burst_end, gap_end, done_q, sq;

    assign start     = state == IDLE && bus.cmd_valid && !bus.cmd_dir[2];
    assign burst_end = bcnt == TW'(TONE_CYCLES - 1);
    assign gap_end   = gcnt == GW'(GAP_CYCLES - 1);
    assign hp_sel    = bus.cmd_dir[1:0] == 2'd0 ? HW'(HP_STRAIGHT)
                     : bus.cmd_dir[1:0] == 2'd1 ? HW'(HP_LEFT)
                     : bus.cmd_dir[1:0] == 2'd2 ? HW'(HP_RIGHT)
                     : HW'(HP_BACK);

    // state register
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end

    // next state: STOP codes are consumed in IDLE without leaving it
    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (start ? TONE : IDLE)
                : state == TONE ? (burst_end ? GAP : TONE)
                : (gap_end ? IDLE : GAP);
    end

    // status outputs decoded from the state register
    always_comb begin
        bus.cmd_ready = state == IDLE;
        bus.active    = state == TONE;
    end

    // half-period is captured at acceptance and frozen for the whole burst
    always_ff @(posedge clk) begin
        hp <= rst ? '0 : start ? hp_sel : hp;
    end

    // burst and gap counters run only in their own state
    always_ff @(posedge clk) begin
        bcnt <= (rst || state != TONE) ? '0 : bcnt + TW'(1);
        gcnt <= (rst || state != GAP) ? '0 : gcnt + GW'(1);
    end

    // done lands in the same cycle cmd_ready returns
    always_ff @(posedge clk) begin
        done_q <= !rst && state == GAP && gap_end;
    end

    tone_divider #(.W(HW)) u_div (
        .clk         (clk),
        .rst         (rst),
        .en          (state_n == TONE),
        .half_period (hp),
        .sq          (sq)
    );

    assign bus.tone_out = sq;
    assign bus.done     = done_q;
endmodule
